// File: rtl/lsu_mem_bridge.sv
// Load/store bridge from the single-cycle core data port to a request/grant/response memory.
// Stalls the core per access, builds lane-aligned byte enables/store data, extends loads, flags errors.
module lsu_mem_bridge #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic [ADDR_W-1:0]   alu_out,
    input  logic [DATA_W-1:0]   mem_wr_d,
    input  logic [1:0]          str_type,
    input  logic                ld_uns,
    output logic                stall,
    output logic [DATA_W-1:0]   mem_rd_d,
    output logic                misalign,
    output logic                err_mis,
    output logic                err_to,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W/8-1:0] m_be,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_gnt,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata
);

    // state | meaning
    // IDLE  | waiting for a core access; aligned access is captured here
    // REQ   | m_req asserted until m_gnt (or timeout)
    // WAIT  | load granted, waiting for m_rvalid (or timeout)
    // DONE  | one cycle, stall released, core retires the instruction

    localparam int          NB      = DATA_W / 8;
    localparam int          OFF_W   = (DATA_W == 64) ? 3 : 2;
    localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [NB-1:0]       r_be;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rd_d;
    logic                r_we;
    logic                r_err_mis;
    logic                r_err_to;
    logic                r_uns;
    logic [1:0]          r_size;
    logic [OFF_W-1:0]    r_off;
    logic [31:0]         r_cnt;

    logic                w_req;
    logic                w_bad;
    logic                w_accept;
    logic                w_reject;
    logic                w_to;
    logic                w_abort;
    logic                w_busy;
    logic                w_sign;
    logic [OFF_W-1:0]    w_off;
    logic [NB-1:0]       w_be_base;
    logic [NB-1:0]       w_be;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_shifted;
    logic [DATA_W-1:0]   w_mask;
    logic [DATA_W-1:0]   w_topbit;
    logic [DATA_W-1:0]   w_ext;
    logic [6:0]          w_nbits;

    assign w_req = mem_rd | mem_wr;
    assign w_off = alu_out[OFF_W-1:0];

    always_comb begin
        w_bad     = 1'b0;
        w_be_base = NB'(1);
        case (str_type)
            2'b00: begin
                w_bad     = 1'b0;
                w_be_base = NB'(1);
            end
            2'b01: begin
                w_bad     = alu_out[0];
                w_be_base = NB'(3);
            end
            2'b10: begin
                w_bad     = |alu_out[1:0];
                w_be_base = NB'(15);
            end
            default: begin
                w_bad     = (DATA_W == 32) || (|alu_out[2:0]);
                w_be_base = NB'(255);
            end
        endcase
    end

    assign w_be     = w_be_base << w_off;
    assign w_wdata  = mem_wr_d << {w_off, 3'b000};
    assign w_accept = (r_state == S_IDLE) && w_req && !w_bad;
    assign w_reject = (r_state == S_IDLE) && w_req && w_bad;
    assign w_busy   = (r_state == S_REQ) || (r_state == S_WAIT);

    // A completing event (store grant, load data) on the last allowed cycle beats the timeout.
    assign w_to    = (TIMEOUT != 0) && (r_cnt == TO_LAST);
    assign w_abort = w_to && (((r_state == S_REQ) && !(m_gnt && r_we)) ||
                              ((r_state == S_WAIT) && !m_rvalid));

    always_comb begin
        w_nbits = 7'd64;
        case (r_size)
            2'b00:   w_nbits = 7'd8;
            2'b01:   w_nbits = 7'd16;
            2'b10:   w_nbits = 7'd32;
            default: w_nbits = 7'd64;
        endcase
    end

    // Masks built by shifting so a full-width access needs no special case.
    assign w_shifted = m_rdata >> {r_off, 3'b000};
    assign w_mask    = ~({DATA_W{1'b1}} << w_nbits);
    assign w_topbit  = DATA_W'(1) << (w_nbits - 7'd1);
    assign w_sign    = |(w_shifted & w_topbit);
    assign w_ext     = (!r_uns && w_sign) ? (w_shifted | ~w_mask) : (w_shifted & w_mask);

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_REQ;
            S_REQ: begin
                if (m_gnt && r_we) w_next = S_DONE;
                else if (w_abort)  w_next = S_DONE;
                else if (m_gnt)    w_next = S_WAIT;
            end
            S_WAIT: if (m_rvalid || w_abort) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        m_req    = (r_state == S_REQ);
        stall    = w_busy || w_accept;
        misalign = w_reject;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_uns     <= 1'b0;
            r_size    <= 2'b00;
            r_off     <= '0;
            r_cnt     <= 32'd0;
            r_rd_d    <= '0;
            r_err_mis <= 1'b0;
            r_err_to  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= alu_out & ~ADDR_W'(NB - 1);
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_we    <= mem_wr;
                r_uns   <= ld_uns;
                r_size  <= str_type;
                r_off   <= w_off;
                r_cnt   <= 32'd0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + 32'd1;
            end

            if (w_reject) begin
                r_rd_d    <= '0;
                r_err_mis <= 1'b1;
            end

            if ((r_state == S_WAIT) && m_rvalid) begin
                r_rd_d <= w_ext;
            end else if (w_abort) begin
                r_rd_d   <= '0;
                r_err_to <= 1'b1;
            end
        end
    end

    assign mem_rd_d = r_rd_d;
    assign err_mis  = r_err_mis;
    assign err_to   = r_err_to;
    assign m_we     = r_we;
    assign m_addr   = r_addr;
    assign m_be     = r_be;
    assign m_wdata  = r_wdata;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Bench for lsu_mem_bridge: a 32-bit instance (TIMEOUT=4) and a 64-bit instance (timeout off)
// share one stimulus bus; an arithmetic reference model predicts every observed value.
module tb_lsu_mem_bridge;

    localparam int TO32 = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sel;
    logic        rd, wr, uns, gnt, rvalid;
    logic [31:0] addr;
    logic [63:0] wd, rdata;
    logic [1:0]  typ;

    logic        a_stall, a_mis, a_emis, a_eto, a_req, a_we;
    logic [31:0] a_rdd, a_addr, a_wdata;
    logic [3:0]  a_be;
    logic        b_stall, b_mis, b_emis, b_eto, b_req, b_we;
    logic [63:0] b_rdd, b_wdata;
    logic [31:0] b_addr;
    logic [7:0]  b_be;

    logic        o_stall, o_mis, o_emis, o_eto, o_req, o_we;
    logic [63:0] o_rdd, o_wdata;
    logic [31:0] o_addr;
    logic [7:0]  o_be;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_rdd [2];
    logic        exp_mis [2];
    logic        exp_to  [2];

    always #5 clk = ~clk;

    lsu_mem_bridge #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO32)) u32 (
        .clk(clk), .rstn(rstn), .mem_rd(rd & ~sel), .mem_wr(wr & ~sel), .alu_out(addr),
        .mem_wr_d(wd[31:0]), .str_type(typ), .ld_uns(uns), .stall(a_stall), .mem_rd_d(a_rdd),
        .misalign(a_mis), .err_mis(a_emis), .err_to(a_eto), .m_req(a_req), .m_we(a_we),
        .m_addr(a_addr), .m_be(a_be), .m_wdata(a_wdata), .m_gnt(gnt), .m_rvalid(rvalid),
        .m_rdata(rdata[31:0])
    );

    lsu_mem_bridge #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(0)) u64 (
        .clk(clk), .rstn(rstn), .mem_rd(rd & sel), .mem_wr(wr & sel), .alu_out(addr),
        .mem_wr_d(wd), .str_type(typ), .ld_uns(uns), .stall(b_stall), .mem_rd_d(b_rdd),
        .misalign(b_mis), .err_mis(b_emis), .err_to(b_eto), .m_req(b_req), .m_we(b_we),
        .m_addr(b_addr), .m_be(b_be), .m_wdata(b_wdata), .m_gnt(gnt), .m_rvalid(rvalid),
        .m_rdata(rdata)
    );

    assign o_stall = sel ? b_stall : a_stall;
    assign o_mis   = sel ? b_mis   : a_mis;
    assign o_emis  = sel ? b_emis  : a_emis;
    assign o_eto   = sel ? b_eto   : a_eto;
    assign o_req   = sel ? b_req   : a_req;
    assign o_we    = sel ? b_we    : a_we;
    assign o_rdd   = sel ? b_rdd   : {32'd0, a_rdd};
    assign o_wdata = sel ? b_wdata : {32'd0, a_wdata};
    assign o_addr  = sel ? b_addr  : a_addr;
    assign o_be    = sel ? b_be    : {4'd0, a_be};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut=%0d got=%0h exp=%0h", tag, sel, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_req"},   64'(o_req),  64'd0);
        check_val({tag, "_we"},    64'(o_we),   64'd0);
        check_val({tag, "_addr"},  64'(o_addr), 64'd0);
        check_val({tag, "_be"},    64'(o_be),   64'd0);
        check_val({tag, "_wdata"}, o_wdata,     64'd0);
        check_val({tag, "_rdd"},   o_rdd,       64'd0);
        check_val({tag, "_emis"},  64'(o_emis), 64'd0);
        check_val({tag, "_eto"},   64'(o_eto),  64'd0);
        check_val({tag, "_stall"}, 64'(o_stall), 64'd0);
    endtask

    // One core access: g = cycles without grant before the grant, r = cycles after grant before rvalid.
    task automatic run_txn(input bit w, input logic [31:0] a, input logic [1:0] t, input logic [63:0] d,
                           input bit u, input int g, input int r, input logic [63:0] rdat);
        int          dw, to, nb, off, busy, nstall, nreq, ireq, di;
        bit          ok, abort;
        logic [63:0] dwm, m, v, e_be, e_wd;
        logic [31:0] e_addr;
        di    = sel ? 1 : 0;
        dw    = sel ? 64 : 32;
        to    = sel ? 0 : TO32;
        dwm   = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        nb    = 1 << t;
        ok    = !(t == 2'd3 && dw == 32) && ((a % nb) == 0);
        off   = int'(a % (dw / 8));
        e_addr = a - 32'(off);
        e_be   = ((64'd1 << nb) - 64'd1) << off;
        e_wd   = (d << (8 * off)) & dwm;

        @(negedge clk);
        wr = w; rd = !w; addr = a; typ = t; wd = d; uns = u; rdata = rdat; gnt = 1'b0; rvalid = 1'b0;
        #1;
        if (!ok) begin
            check_val("mis_flag",  64'(o_mis),   64'd1);
            check_val("mis_stall", 64'(o_stall), 64'd0);
            check_val("mis_noreq", 64'(o_req),   64'd0);
            @(negedge clk);
            rd = 1'b0; wr = 1'b0;
            #1;
            exp_rdd[di] = 64'd0;
            exp_mis[di] = 1'b1;
            check_val("mis_noreq2", 64'(o_req),  64'd0);
            check_val("mis_rdd",    o_rdd,       exp_rdd[di]);
            check_val("mis_errmis", 64'(o_emis), 64'(exp_mis[di]));
            return;
        end
        check_val("idle_stall", 64'(o_stall), 64'd1);
        check_val("idle_mis",   64'(o_mis),   64'd0);

        busy  = w ? g + 1 : g + r + 2;
        abort = (to > 0) && (busy > to);
        if (abort) busy = to;
        ireq  = (g + 1 < busy) ? g + 1 : busy;
        nstall = 1;
        nreq   = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            gnt    = (c == g + 1);
            rvalid = (!w && c == g + r + 2);
            #1;
            if (c == 1) begin
                check_val("req_on",  64'(o_req),   64'd1);
                check_val("be",      64'(o_be),    e_be);
                check_val("wdata",   o_wdata,      e_wd);
                check_val("we",      64'(o_we),    64'(w));
            end
            if (o_req) begin
                nreq++;
                check_val("addr_hold", 64'(o_addr), 64'(e_addr));
            end
            if (!o_stall) break;
            nstall++;
        end
        gnt = 1'b0; rvalid = 1'b0; rd = 1'b0; wr = 1'b0;
        check_val("stall_cycles", 64'(nstall), 64'(busy + 1));
        check_val("req_cycles",   64'(nreq),   64'(ireq));

        if (abort) begin
            exp_rdd[di] = 64'd0;
            exp_to[di]  = 1'b1;
        end else if (!w) begin
            v = (rdat & dwm) >> (8 * off);
            if (nb < 8) begin
                m = (64'd1 << (8 * nb)) - 64'd1;
                v = v & m;
                if (!u && v[8 * nb - 1]) v = v | ~m;
            end
            exp_rdd[di] = v & dwm;
        end
        check_val("rd_data", o_rdd,       exp_rdd[di]);
        check_val("err_to",  64'(o_eto),  64'(exp_to[di]));
        check_val("err_mis", 64'(o_emis), 64'(exp_mis[di]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        logic [31:0] ra;
        logic [1:0]  rt;
        int          rnb;
        rstn = 1'b0; sel = 1'b0; rd = 1'b0; wr = 1'b0; uns = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        addr = '0; wd = '0; rdata = '0; typ = 2'b00;
        for (int i = 0; i < 2; i++) begin
            exp_rdd[i] = 64'd0; exp_mis[i] = 1'b0; exp_to[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("rst32");
        sel = 1'b1;
        #1;
        check_all_zero("rst64");
        sel = 1'b0;
        rstn = 1'b1;

        // 32-bit directed cases
        run_txn(1'b1, 32'h104, 2'd2, 64'hA1B2C3D4, 1'b0, 0, 0, 64'd0);
        run_txn(1'b0, 32'h103, 2'd0, 64'd0, 1'b0, 0, 0, 64'h80FFFFFF);
        run_txn(1'b0, 32'h103, 2'd0, 64'd0, 1'b1, 1, 1, 64'h80FFFFFF);
        run_txn(1'b1, 32'h202, 2'd1, 64'h1234, 1'b0, 2, 0, 64'd0);
        run_txn(1'b0, 32'h201, 2'd2, 64'd0, 1'b0, 0, 0, 64'h55);
        run_txn(1'b0, 32'h206, 2'd1, 64'd0, 1'b0, 0, 1, 64'h8001_7FFF);
        run_txn(1'b1, 32'h040, 2'd2, 64'h11, 1'b0, 10, 0, 64'd0);
        @(negedge clk);
        rvalid = 1'b1; rdata = 64'h1234_5678;
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        check_val("stale_rvalid", o_rdd, 64'd0);
        run_txn(1'b0, 32'h300, 2'd2, 64'd0, 1'b0, 0, 2, 64'hCAFE_F00D);
        run_txn(1'b0, 32'h300, 2'd2, 64'd0, 1'b0, 0, 5, 64'hCAFE_F00D);

        // 64-bit directed cases
        sel = 1'b1;
        run_txn(1'b1, 32'h10, 2'd3, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 0, 64'd0);
        run_txn(1'b0, 32'h14, 2'd3, 64'd0, 1'b0, 0, 0, 64'd1);
        run_txn(1'b0, 32'h18, 2'd3, 64'd0, 1'b0, 1, 1, 64'hFEDC_BA98_7654_3210);
        run_txn(1'b0, 32'h1C, 2'd2, 64'd0, 1'b0, 0, 0, 64'h9000_0000_1234_5678);
        run_txn(1'b1, 32'h1D, 2'd0, 64'hAB, 1'b0, 6, 0, 64'd0);

        // reset in the middle of WAIT abandons the load
        sel = 1'b0;
        run_txn(1'b0, 32'h300, 2'd2, 64'd0, 1'b0, 0, 0, 64'hDEAD_BEEF);
        @(negedge clk);
        rd = 1'b1; wr = 1'b0; addr = 32'h300; typ = 2'd2;
        @(negedge clk);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        rstn = 1'b0; rd = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("rst_wait");
        for (int i = 0; i < 2; i++) begin
            exp_rdd[i] = 64'd0; exp_mis[i] = 1'b0; exp_to[i] = 1'b0;
        end
        rstn = 1'b1;
        rvalid = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        check_val("rst_stale_rvalid", o_rdd, 64'd0);

        // randomized accesses on both widths
        for (int n = 0; n < 120; n++) begin
            sel = 1'($urandom_range(0, 1));
            rt  = 2'($urandom_range(0, 3));
            rnb = 1 << rt;
            ra  = 32'h1000 + 32'($urandom_range(0, 255)) * 32'd8;
            if ($urandom_range(0, 4) == 0) ra = ra + 32'($urandom_range(0, 7));
            else                           ra = ra + (32'($urandom_range(0, 7)) & ~32'(rnb - 1));
            run_txn(1'($urandom_range(0, 1)), ra, rt, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
